// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, bus widths,
// grant-source encoding and the word-alignment helper.
package mips_mem_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_BUSY = 3'd1,
        I_BUSY = 3'd2,
        D_DONE = 3'd3,
        I_DONE = 3'd4
    } arb_state_e;

    typedef enum logic {
        GNT_D = 1'b0,
        GNT_I = 1'b1
    } gnt_src_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory req/ack bus; master is the arbiter, slave is the memory.
interface mem_port_arbiter_if;
    import mips_mem_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for a BUSY access; expired flags the last allowed cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                count <= '0;
        else if (clr)             count <= '0;
        else if (en && !expired)  count <= count + W'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and MEM-stage data accesses onto one req/ack memory port,
// producing done pulses and pipeline stalls for both requesters.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              stall_mem,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    output logic              stall_if,
    mem_port_arbiter_if.master mem
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e    state, state_nxt;
    logic [SW-1:0] starve, starve_nxt;
    gnt_src_e      gsrc;
    logic          dreq, grant, mis_done, busy_end, end_err, expired;

    assign dreq      = d_read | d_write;
    assign stall_mem = dreq & ~d_done;
    assign stall_if  = i_req & ~i_done;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (grant),
        .en      (state == D_BUSY || state == I_BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve;
        gsrc       = GNT_D;
        grant      = 1'b0;
        mis_done   = 1'b0;
        busy_end   = 1'b0;
        end_err    = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch has already lost STARVE_LIMIT times in a row.
                if (dreq && (!i_req || starve < STARVE_MAX)) begin
                    if (i_req) starve_nxt = starve + SW'(1);
                    if (d_addr[1:0] != 2'b00) begin
                        mis_done  = 1'b1;
                        state_nxt = D_DONE;
                    end else begin
                        grant     = 1'b1;
                        state_nxt = D_BUSY;
                    end
                end else if (i_req) begin
                    gsrc       = GNT_I;
                    starve_nxt = '0;
                    grant      = 1'b1;
                    state_nxt  = I_BUSY;
                end
            end
            D_BUSY, I_BUSY: begin
                if (mem.ack || expired) begin
                    busy_end  = 1'b1;
                    end_err   = ~mem.ack;
                    state_nxt = (state == D_BUSY) ? D_DONE : I_DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
        end else begin
            d_done <= 1'b0;
            i_done <= 1'b0;
            if (grant) begin
                mem.req   <= 1'b1;
                mem.we    <= (gsrc == GNT_D) && d_write;
                mem.addr  <= word_align((gsrc == GNT_D) ? d_addr : i_addr);
                mem.wdata <= d_wdata;
            end
            if (mis_done) begin
                d_done  <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
            end
            if (busy_end) begin
                mem.req <= 1'b0;
                if (state == D_BUSY) begin
                    d_done  <= 1'b1;
                    d_err   <= end_err;
                    d_rdata <= (end_err || mem.we) ? '0 : mem.rdata;
                end else begin
                    i_done  <= 1'b1;
                    i_err   <= end_err;
                    i_rdata <= end_err ? '0 : mem.rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, contention, starvation, misalign,
// timeout and reset-during-access.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        d_read, d_write, i_req;
    logic [31:0] d_addr, d_wdata, i_addr;
    logic        d_done, d_err, stall_mem, i_done, i_err, stall_if;
    logic [31:0] d_rdata, i_rdata;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_port_arbiter_if mem();

    mem_port_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .stall_mem (stall_mem),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .stall_if  (stall_if),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next grant, acks it in its first BUSY cycle, reports mem_we.
    task automatic serve(input logic [31:0] rd, output logic we_seen);
        int n = 0;
        we_seen = 1'b0;
        do begin
            cyc();
            n++;
        end while (!mem.req && n < 8);
        chk("serve_grant", {31'b0, mem.req}, 32'd1);
        we_seen   = mem.we;
        mem.ack   = 1'b1;
        mem.rdata = rd;
        cyc();
        mem.ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       w;
        logic [5:0] exp_we;
        int         hi;

        reset = 1'b1;
        d_read = 0; d_write = 0; i_req = 0;
        d_addr = 0; d_wdata = 0; i_addr = 0;
        mem.ack = 0; mem.rdata = 0;
        #12;
        chk("rst_req",    {31'b0, mem.req}, 32'd0);
        chk("rst_addr",   mem.addr, 32'd0);
        chk("rst_d_done", {31'b0, d_done}, 32'd0);
        chk("rst_i_done", {31'b0, i_done}, 32'd0);
        cyc();
        reset = 1'b0;

        // Aligned load, ack in first BUSY cycle.
        cyc(); d_read = 1; d_addr = 32'h100;
        @(negedge clk);
        chk("ld_stall1", {31'b0, stall_mem}, 32'd1);
        chk("ld_req1",   {31'b0, mem.req}, 32'd0);
        cyc(); mem.ack = 1; mem.rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld_req2",   {31'b0, mem.req}, 32'd1);
        chk("ld_addr",   mem.addr, 32'h100);
        chk("ld_we",     {31'b0, mem.we}, 32'd0);
        chk("ld_stall2", {31'b0, stall_mem}, 32'd1);
        cyc(); mem.ack = 0;
        @(negedge clk);
        chk("ld_done",  {31'b0, d_done}, 32'd1);
        chk("ld_rdata", d_rdata, 32'hDEADBEEF);
        chk("ld_err",   {31'b0, d_err}, 32'd0);
        chk("ld_req3",  {31'b0, mem.req}, 32'd0);
        chk("ld_stall3",{31'b0, stall_mem}, 32'd0);
        cyc(); d_read = 0;
        @(negedge clk);
        chk("ld_done_off", {31'b0, d_done}, 32'd0);

        // Store and fetch together: data first, fetch after D_DONE.
        cyc(); d_write = 1; d_addr = 32'h200; d_wdata = 32'h12345678; i_req = 1; i_addr = 0;
        @(negedge clk);
        chk("mix_stall_if", {31'b0, stall_if}, 32'd1);
        cyc(); mem.ack = 1; mem.rdata = 32'hAAAA5555;
        @(negedge clk);
        chk("mix_we",    {31'b0, mem.we}, 32'd1);
        chk("mix_wdata", mem.wdata, 32'h12345678);
        chk("mix_addr",  mem.addr, 32'h200);
        cyc(); mem.ack = 0;
        @(negedge clk);
        chk("mix_d_done",  {31'b0, d_done}, 32'd1);
        chk("mix_d_rdata", d_rdata, 32'd0);
        chk("mix_i_done0", {31'b0, i_done}, 32'd0);
        cyc(); d_write = 0;
        @(negedge clk);
        chk("mix_idle_req", {31'b0, mem.req}, 32'd0);
        cyc(); mem.ack = 1; mem.rdata = 32'h8C010004;
        @(negedge clk);
        chk("mix_i_req", {31'b0, mem.req}, 32'd1);
        chk("mix_i_we",  {31'b0, mem.we}, 32'd0);
        chk("mix_i_addr", mem.addr, 32'h0);
        cyc(); mem.ack = 0;
        @(negedge clk);
        chk("mix_i_done",  {31'b0, i_done}, 32'd1);
        chk("mix_i_rdata", i_rdata, 32'h8C010004);
        chk("mix_i_err",   {31'b0, i_err}, 32'd0);
        cyc(); i_req = 0;

        // Starvation: four data wins, then fetch, then data again.
        d_write = 1; d_addr = 32'h300; i_req = 1; i_addr = 32'h20;
        exp_we = 6'b101111;
        for (int g = 0; g < 6; g++) begin
            serve(32'h0, w);
            chk($sformatf("starve_g%0d", g), {31'b0, w}, {31'b0, exp_we[g]});
        end
        d_write = 0; i_req = 0;
        cyc();

        // Misaligned load: no memory cycle, error done after two cycles.
        cyc(); d_read = 1; d_addr = 32'h102;
        @(negedge clk);
        chk("mis_req1", {31'b0, mem.req}, 32'd0);
        cyc();
        @(negedge clk);
        chk("mis_done",  {31'b0, d_done}, 32'd1);
        chk("mis_err",   {31'b0, d_err}, 32'd1);
        chk("mis_rdata", d_rdata, 32'd0);
        chk("mis_req2",  {31'b0, mem.req}, 32'd0);
        cyc(); d_read = 0;

        // Fetch timeout: req high exactly 16 cycles, then error done.
        cyc(); i_req = 1; i_addr = 32'h40;
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem.req) hi++;
            else if (hi > 0) break;
        end
        chk("to_req_cycles", hi, 32'd16);
        chk("to_done", {31'b0, i_done}, 32'd1);
        chk("to_err",  {31'b0, i_err}, 32'd1);
        cyc(); i_req = 0;

        // Stray ack while idle is ignored.
        cyc(); mem.ack = 1;
        cyc(); mem.ack = 0;
        @(negedge clk);
        chk("idle_ack_d", {31'b0, d_done}, 32'd0);
        chk("idle_ack_i", {31'b0, i_done}, 32'd0);

        // Reset in BUSY drops req at once; a late ack afterwards does nothing.
        cyc(); i_req = 1; i_addr = 32'h80;
        cyc();
        chk("rb_req_on", {31'b0, mem.req}, 32'd1);
        #2 reset = 1;
        #1;
        chk("rb_req_off", {31'b0, mem.req}, 32'd0);
        i_req = 0;
        cyc(); reset = 0; mem.ack = 1; mem.rdata = 32'h11112222;
        cyc(); mem.ack = 0;
        @(negedge clk);
        chk("rb_i_done", {31'b0, i_done}, 32'd0);
        chk("rb_req",    {31'b0, mem.req}, 32'd0);
        cyc();
        @(negedge clk);
        chk("rb_i_done2", {31'b0, i_done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
